// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the configurable UART
//                transmitter (FSM encoding, parity codes, length limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter FSM states, explicitly encoded so the state register
  // stays 3 bits wide and its values are stable for debug.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity selector codes; 2'b11 is treated as none.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Shortest supported data field.
  localparam int MIN_DATA_LEN = 5;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo
//  Description : Synchronous TX FIFO with first-word-fall-through read data,
//                occupancy level and a registered overflow pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_do_wr;
  logic             w_do_rd;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_do_wr = wr_en_i && !w_full;
  assign w_do_rd = rd_en_i && !w_empty;

  // Storage array; no reset needed since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din_i;
    end
  end

  // Pointers, occupancy count and overflow pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en_i && w_full;
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout_o     = r_mem[r_rd_ptr];
  assign full_o     = w_full;
  assign empty_o    = w_empty;
  assign level_o    = r_count;
  assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Configurable UART transmitter: 5..DATA_WIDTH data bits,
//                none/odd/even parity, 1 or 2 stop bits, break generator,
//                TX FIFO with level and overflow reporting, registered line.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIV_WIDTH-1:0]          baud_div_i,
  input  logic [3:0]                    data_len_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          tx_en_i,
  input  logic                          break_i,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         din_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          tx_o
);

  localparam logic [3:0]           c_min_len = 4'(MIN_DATA_LEN);
  localparam logic [3:0]           c_max_len = 4'(DATA_WIDTH);
  localparam logic [DIV_WIDTH-1:0] c_div_one = DIV_WIDTH'(1);

  // FSM and output registers
  state_t                r_state;
  logic [DIV_WIDTH-1:0]  r_baud_cnt;
  logic [3:0]            r_bit_cnt;
  logic                  r_stop_cnt;
  logic                  r_tx;
  logic                  r_done;

  // Per-frame configuration, captured when a word is popped
  logic [DATA_WIDTH-1:0] r_word;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [3:0]            r_len;
  logic [1:0]            r_par;
  logic                  r_stop2;

  logic [DATA_WIDTH-1:0] w_fifo_dout;
  logic                  w_empty;
  logic                  w_pop;
  logic [DIV_WIDTH-1:0]  w_div;
  logic [3:0]            w_len;
  logic [1:0]            w_par;
  logic                  w_bit_end;
  logic                  w_last_data;
  logic                  w_last_stop;
  logic                  w_can_start;
  logic [3:0]            w_bit_nxt;
  logic [DATA_WIDTH-1:0] w_word_sh;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_xor;
  logic                  w_par_bit;

  uart_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_en_i    (wr_en_i),
    .din_i      (din_i),
    .rd_en_i    (w_pop),
    .dout_o     (w_fifo_dout),
    .full_o     (full_o),
    .empty_o    (w_empty),
    .level_o    (level_o),
    .overflow_o (overflow_o)
  );

  // Sanitised configuration: divisor 0 acts as 1, length clamped, 2'b11 = none.
  assign w_div = (baud_div_i == '0) ? c_div_one : baud_div_i;
  assign w_len = (data_len_i < c_min_len) ? c_min_len :
                 (data_len_i > c_max_len) ? c_max_len : data_len_i;
  assign w_par = ((parity_i == PAR_ODD) || (parity_i == PAR_EVEN)) ? parity_i : PAR_NONE;

  // Bit timing and frame position decodes.
  assign w_bit_end   = (r_baud_cnt == (r_div - c_div_one));
  assign w_last_data = (r_bit_cnt == (r_len - 4'd1));
  assign w_last_stop = w_bit_end && (!r_stop2 || r_stop_cnt);
  assign w_can_start = tx_en_i && !w_empty;
  assign w_pop       = w_can_start &&
                       ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_last_stop));

  // Next data bit via shift so the index width never exceeds the word.
  assign w_bit_nxt = r_bit_cnt + 4'd1;
  assign w_word_sh = r_word >> w_bit_nxt;

  // Parity covers only the active data bits of the frame.
  assign w_mask    = ~({DATA_WIDTH{1'b1}} << r_len);
  assign w_xor     = ^(r_word & w_mask);
  assign w_par_bit = (r_par == PAR_ODD) ? ~w_xor : w_xor;

  // Capture the word and its configuration whenever a frame is launched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_word  <= '0;
      r_div   <= c_div_one;
      r_len   <= c_min_len;
      r_par   <= PAR_NONE;
      r_stop2 <= 1'b0;
    end else if (w_pop) begin
      r_word  <= w_fifo_dout;
      r_div   <= w_div;
      r_len   <= w_len;
      r_par   <= w_par;
      r_stop2 <= stop2_i;
    end
  end

  // Frame sequencer: baud counter, bit/stop counters and the registered line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_baud_cnt <= w_bit_end ? '0 : (r_baud_cnt + c_div_one);
      end
      case (r_state)
        ST_IDLE: begin
          r_tx <= ~break_i;
          if (w_can_start) begin
            r_state    <= ST_START;
            r_tx       <= 1'b0;
            r_baud_cnt <= '0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= '0;
            r_tx      <= r_word[0];
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (!w_last_data) begin
              r_bit_cnt <= w_bit_nxt;
              r_tx      <= w_word_sh[0];
            end else if (r_par != PAR_NONE) begin
              r_state <= ST_PARITY;
              r_tx    <= w_par_bit;
            end else begin
              r_state    <= ST_STOP;
              r_stop_cnt <= 1'b0;
              r_tx       <= 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_end) begin
            r_state    <= ST_STOP;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_last_stop) begin
            r_done <= 1'b1;
            if (w_can_start) begin
              r_state <= ST_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_tx    <= 1'b1;
            end
          end else if (w_bit_end) begin
            r_stop_cnt <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign empty_o = w_empty;
  assign busy_o  = (r_state != ST_IDLE);
  assign done_o  = r_done;
  assign tx_o    = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Directed self-checking bench for uart_tx_cfg. Expected line
//                patterns are listed LSB first (bit 0 = start bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] baud_div_i;
  logic [3:0]  data_len_i;
  logic [1:0]  parity_i;
  logic        stop2_i;
  logic        tx_en_i;
  logic        break_i;
  logic        wr_en_i;
  logic [7:0]  din_i;
  logic        full_o;
  logic        empty_o;
  logic [4:0]  level_o;
  logic        overflow_o;
  logic        busy_o;
  logic        done_o;
  logic        tx_o;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  int done_base = 0;

  uart_tx_cfg #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .DIV_WIDTH  (16)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .baud_div_i (baud_div_i),
    .data_len_i (data_len_i),
    .parity_i   (parity_i),
    .stop2_i    (stop2_i),
    .tx_en_i    (tx_en_i),
    .break_i    (break_i),
    .wr_en_i    (wr_en_i),
    .din_i      (din_i),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .tx_o       (tx_o)
  );

  always #5 clk_i = ~clk_i;

  // Count done pulses on the active edge; read only from negedge points.
  always @(posedge clk_i) begin
    if (done_o === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle FIFO write; called and returns at a falling edge.
  task automatic send_word(input logic [7:0] w);
    wr_en_i = 1'b1;
    din_i   = w;
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  // Frame must start right after the next rising edge; every cycle is checked.
  task automatic expect_frame(input string tag, input int div, input int nbits,
                              input logic [15:0] pat);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk_i);
        chk($sformatf("%s_b%0d_c%0d", tag, b, c), tx_o, pat[b]);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; baud_div_i = 16'd4; data_len_i = 4'd8; parity_i = 2'b00;
    stop2_i = 1'b0; tx_en_i = 1'b0; break_i = 1'b0; wr_en_i = 1'b0; din_i = 8'h00;
    repeat (2) @(negedge clk_i);

    // Reset state
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_level", level_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // 8N1, div 4, 0xA5
    tx_en_i = 1'b1;
    done_base = done_seen;
    send_word(8'hA5);
    chk("t1_empty_fall", empty_o, 0);
    chk("t1_level", level_o, 1);
    chk("t1_idle_tx", tx_o, 1);
    expect_frame("t1", 4, 10, 16'h034A);
    @(negedge clk_i);
    chk("t1_done", done_o, 1);
    chk("t1_busy_after", busy_o, 0);
    chk("t1_empty_after", empty_o, 1);
    @(negedge clk_i);
    chk("t1_done_count", done_seen - done_base, 1);

    // 7E2, div 3, 0x41
    baud_div_i = 16'd3; data_len_i = 4'd7; parity_i = 2'b10; stop2_i = 1'b1;
    send_word(8'h41);
    expect_frame("t2", 3, 11, 16'h0682);
    @(negedge clk_i);
    chk("t2_done", done_o, 1);

    // 8O1 / 8E1, div 2
    baud_div_i = 16'd2; data_len_i = 4'd8; parity_i = 2'b01; stop2_i = 1'b0;
    send_word(8'h00);
    expect_frame("t3_odd00", 2, 11, 16'h0600);
    @(negedge clk_i);
    send_word(8'hFF);
    expect_frame("t3_oddFF", 2, 11, 16'h07FE);
    @(negedge clk_i);
    parity_i = 2'b10;
    send_word(8'hFF);
    expect_frame("t3_evenFF", 2, 11, 16'h05FE);
    @(negedge clk_i);

    // Fill to full with divisor 0 (=1), length 15 (=8), parity 11 (=none)
    tx_en_i = 1'b0; baud_div_i = 16'd0; data_len_i = 4'd15; parity_i = 2'b11;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t4_not_full_15", full_o, 0);
      wr_en_i = 1'b1;
      din_i   = 8'(i * 17);
      @(negedge clk_i);
    end
    chk("t4_full", full_o, 1);
    chk("t4_level16", level_o, 16);
    din_i = 8'hAB;
    @(negedge clk_i);
    wr_en_i = 1'b0;
    chk("t4_ovf_pulse", overflow_o, 1);
    chk("t4_level_hold", level_o, 16);
    @(negedge clk_i);
    chk("t4_ovf_clear", overflow_o, 0);
    done_base = done_seen;
    tx_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expect_frame($sformatf("t4_f%0d", i), 1, 10, {6'b0, 1'b1, 8'(i * 17), 1'b0});
    end
    @(negedge clk_i);
    chk("t4_done_last", done_o, 1);
    chk("t4_busy_after", busy_o, 0);
    chk("t4_empty_after", empty_o, 1);
    @(negedge clk_i);
    chk("t4_done_count", done_seen - done_base, 16);

    // Asynchronous reset in the middle of the data field
    baud_div_i = 16'd4; data_len_i = 4'd8; parity_i = 2'b00; tx_en_i = 1'b0;
    send_word(8'hF0);
    send_word(8'h33);
    chk("t5_level2", level_o, 2);
    tx_en_i = 1'b1;
    repeat (7) @(negedge clk_i);
    chk("t5_busy_mid", busy_o, 1);
    chk("t5_level_mid", level_o, 1);
    chk("t5_tx_mid", tx_o, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_rst_tx", tx_o, 1);
    chk("t5_rst_busy", busy_o, 0);
    chk("t5_rst_empty", empty_o, 1);
    chk("t5_rst_level", level_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("t5_idle_tx", tx_o, 1);
    chk("t5_idle_busy", busy_o, 0);
    send_word(8'h3C);
    expect_frame("t5_refill", 4, 10, 16'h0278);
    @(negedge clk_i);
    chk("t5_done", done_o, 1);

    // Break while idle
    tx_en_i = 1'b0;
    break_i = 1'b1;
    @(negedge clk_i);
    chk("t6_break_tx", tx_o, 0);
    chk("t6_break_busy", busy_o, 0);
    break_i = 1'b0;
    @(negedge clk_i);
    chk("t6_release_tx", tx_o, 1);

    // Break, config change and tx_en drop mid-frame leave the frame intact
    send_word(8'hA5);
    send_word(8'h5A);
    chk("t6_level2", level_o, 2);
    tx_en_i = 1'b1;
    break_i = 1'b1;
    fork
      begin
        repeat (3) @(negedge clk_i);
        baud_div_i = 16'd1; data_len_i = 4'd5; parity_i = 2'b01; stop2_i = 1'b1;
        tx_en_i = 1'b0;
      end
    join_none
    expect_frame("t6_frame", 4, 10, 16'h034A);
    break_i = 1'b0;
    @(negedge clk_i);
    chk("t6_done", done_o, 1);
    chk("t6_busy_after", busy_o, 0);
    chk("t6_level_left", level_o, 1);
    @(negedge clk_i);
    chk("t6_stay_idle", busy_o, 0);
    chk("t6_idle_tx", tx_o, 1);
    baud_div_i = 16'd2; data_len_i = 4'd8; parity_i = 2'b00; stop2_i = 1'b0;
    tx_en_i = 1'b1;
    expect_frame("t6_next", 2, 10, 16'h02B4);
    @(negedge clk_i);
    chk("t6_next_done", done_o, 1);
    chk("t6_final_empty", empty_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Configurable UART transmitter, the parametrised successor of the existing fixed 8N1 transmitter.
- Runtime-selectable data length (5..DATA_WIDTH bits), parity (none/odd/even), and 1 or 2 stop bits.
- Adds a registered TX line, a break generator, FIFO fill level and overflow reporting.
- Sits between the CPU/bus register block (writes bytes, sets config) and the tx pad.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame and FIFO word width (5..9)
FIFO_DEPTH, 16, TX FIFO entries (power of two, >=2)
DIV_WIDTH, 16, width of baud divisor

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
baud_div_i  in  DIV_WIDTH  clock cycles per bit; 0 treated as 1
data_len_i  in  4  data bits per frame; <5 treated as 5, >DATA_WIDTH treated as DATA_WIDTH
parity_i  in  2  00 none, 01 odd, 10 even, 11 treated as none
stop2_i  in  1  0 = one stop bit, 1 = two stop bits
tx_en_i  in  1  permits starting new frames
break_i  in  1  hold line low while idle
wr_en_i  in  1  push din_i into FIFO
din_i  in  DATA_WIDTH  write data, LSB transmitted first
full_o  out  1  FIFO full
empty_o  out  1  FIFO empty
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow_o  out  1  one-cycle pulse: write dropped because FIFO full
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at end of last stop bit
tx_o  out  1  serial line, registered

Behaviour:
Reset values (asynchronous on rst_i):
- tx_o=1, busy_o=0, done_o=0, overflow_o=0, empty_o=1, full_o=0, level_o=0.
- State IDLE, all counters 0, FIFO emptied.
- A reset asserted mid-frame aborts the frame; tx_o returns high immediately.

FIFO:
- Write when full is dropped and overflow_o pulses, even if a pop happens in the same cycle.
- Write and pop in the same cycle when not full: level_o unchanged.
- Write to an empty FIFO: empty_o falls the next cycle.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_o = ~break_i, registered.
  - If tx_en_i && !empty_o: pop the FIFO, latch word, baud_div, data_len, parity and stop2 into frame registers, go to START.
  - tx_o goes low on the cycle after the condition is seen.
  - break_i is ignored outside IDLE.
- Bit timing:
  - Baud counter runs 0..div-1 in every non-IDLE state; each bit lasts exactly div cycles.
  - The counter clears on every state/bit change.
- START: tx_o=0 for one bit, then DATA.
- DATA:
  - tx_o = word[bit_cnt], bit_cnt counting 0..len-1.
  - After bit len-1, go to PARITY if parity is enabled, else STOP.
- PARITY:
  - even: tx_o = XOR of the len data bits.
  - odd: tx_o = inverted XOR.
  - Bits above len are excluded from the XOR.
- STOP:
  - tx_o=1 for one bit, or two bits when stop2 is latched.
  - At the end of the final stop bit, done_o pulses.
  - If tx_en_i && !empty_o: pop and go directly to START with no idle gap, re-latching config.
  - Otherwise go to IDLE.

Frame rules:
- Frame length = div*(1+len+P+S) cycles, where P = 1 if parity is enabled and S = 1 or 2 stop bits.
- Config input changes mid-frame have no effect until the next frame.
- tx_en_i deassert mid-frame: the current frame completes, then IDLE.

Decomposition:
- Package uart_pkg: state_t enum; PAR_NONE/PAR_ODD/PAR_EVEN constants; MIN_DATA_LEN=5.
- Sub-module uart_fifo: synchronous FIFO, async active-high reset, first-word-fall-through read data, full/empty/level outputs.
- The FSM, baud counter, parity and output register stay in uart_tx_cfg.

Test Plan:
- div=4, 8N1, write 0xA5, tx_en=1 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); done_o pulses once; empty_o=1 afterwards.
- div=3, len=7, even parity, stop2=1, write 0x41 -> start, 1000001 sent LSB first, parity 0, two stop bits; 33 cycles total.
- div=2, 8 bits, odd parity, write 0x00 -> parity bit 1. Then write 0xFF -> odd parity bit 1, even parity bit 0.
- tx_en=0, write 17 words -> full_o=1 and level_o=16 after 16 writes; the 17th write gives an overflow_o pulse and level stays 16. Then enable -> 16 back-to-back frames with no idle cycle between stop and start.
- Assert rst_i mid-DATA -> tx_o=1 in the same cycle, FIFO empty, busy_o=0. After release with the FIFO refilled, the next frame is correct.
- Idle with break_i=1 -> tx_o=0 the next cycle; release -> tx_o=1. break_i during a frame -> frame unaffected.
